// File: rtl/code_capture_fifo_pkg.sv
// Shared definitions for the code capture path: code width and qualifier state encoding.
// Encoding 2'd3 is unused and recovers to ST_IDLE.
package code_capture_fifo_pkg;

    localparam int CODE_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_QUAL = 2'd1,
        ST_HELD = 2'd2
    } qual_state_e;

endpackage

// File: rtl/code_capture_fifo_sync_fifo.sv
// First-word fall-through synchronous FIFO with occupancy level.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module sync_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             wr_en, rd_en;

    assign empty = (level_q == '0);
    assign full  = (level_q == LVL_FULL);
    assign level = level_q;
    assign rdata = empty ? '0 : mem_q[rd_ptr_q];

    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        if (wr_en) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
    end

    // Storage needs no reset: level gates every read.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/code_capture_fifo.sv
// Stability qualifier for priority-encoder codes feeding a FWFT event FIFO.
// state   | meaning
// IDLE    | no line active, waiting for a press
// QUAL    | counting identical active samples of cand
// HELD    | cand emitted once, counting inactive samples to accept the release
module code_capture_fifo
    import code_capture_fifo_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int DEPTH         = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CODE_W-1:0]        code_in,
    input  logic                     none_in,
    output logic                     out_valid,
    output logic [CODE_W-1:0]        out_code,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    input  logic                     ovf_clr
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    qual_state_e       state_q, state_d;
    logic [CODE_W-1:0] cand_q, cand_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              overflow_q, overflow_d;
    logic [CNT_W-1:0]  cnt_inc;
    logic              active, push, pop, drop;
    logic              fifo_empty, fifo_full;

    assign active  = !none_in;
    assign cnt_inc = cnt_q + CNT_ONE;

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        push    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (active) begin
                    cand_d = code_in;
                    if (CNT_LAST == CNT_ONE) begin
                        push    = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_HELD;
                    end else begin
                        cnt_d   = CNT_ONE;
                        state_d = ST_QUAL;
                    end
                end
            end
            ST_QUAL: begin
                if (!active) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (code_in != cand_q) begin
                    cand_d = code_in;
                    cnt_d  = CNT_ONE;
                end else if (cnt_inc == CNT_LAST) begin
                    push    = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_HELD;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_HELD: begin
                if (active) begin
                    if (code_in == cand_q) begin
                        cnt_d = '0;
                    end else if (CNT_LAST == CNT_ONE) begin
                        // single-sample qualification: a roll-over is already stable
                        cand_d = code_in;
                        push   = 1'b1;
                        cnt_d  = '0;
                    end else begin
                        cand_d  = code_in;
                        cnt_d   = CNT_ONE;
                        state_d = ST_QUAL;
                    end
                end else if (cnt_inc == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign pop  = out_valid && out_ready;
    assign drop = push && fifo_full && !pop;

    always_comb begin
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cand_q     <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cand_q     <= cand_d;
            cnt_q      <= cnt_d;
            overflow_q <= overflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign out_valid = !fifo_empty;

    sync_fifo #(
        .WIDTH (CODE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (cand_d),
        .rdata (out_code),
        .empty (fifo_empty),
        .full  (fifo_full),
        .level (level)
    );

endmodule

// File: tb/tb_code_capture_fifo.sv
// Bench for code_capture_fifo: directed press scenarios plus random traffic,
// compared against a run-length event model and a queue-based FIFO model.
module tb_code_capture_fifo;

    localparam int SC    = 4;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] code_in;
    logic       none_in;
    logic       out_valid;
    logic [2:0] out_code;
    logic       out_ready;
    logic [3:0] level;
    logic       overflow;
    logic       ovf_clr;

    always #5 clk = ~clk;

    code_capture_fifo #(.STABLE_CYCLES(SC), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .code_in   (code_in),
        .none_in   (none_in),
        .out_valid (out_valid),
        .out_code  (out_code),
        .out_ready (out_ready),
        .level     (level),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: queue of events, sticky flag, and run-length tracking of samples.
    int q_m[$];
    bit ovf_m;
    bit held_m;
    int held_code_m;
    bit last_valid_m;
    int last_key_m;
    int run_len_m;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_update(input bit r, input bit n, input int c,
                                         input bit rdy, input bit clr);
        bit push, pop, full, drop;
        int key;
        if (r) begin
            q_m.delete();
            ovf_m        = 0;
            held_m       = 0;
            last_valid_m = 0;
            run_len_m    = 0;
            return;
        end
        key = n ? 8 : c;
        run_len_m    = (last_valid_m && key == last_key_m) ? run_len_m + 1 : 1;
        last_key_m   = key;
        last_valid_m = 1;
        push = 0;
        if (!n) begin
            if (held_m && c != held_code_m) held_m = 0;
            if (!held_m && run_len_m == SC) begin
                push        = 1;
                held_m      = 1;
                held_code_m = c;
            end
        end else if (held_m && run_len_m == SC) begin
            held_m = 0;
        end
        pop  = (q_m.size() > 0) && rdy;
        full = (q_m.size() == DEPTH);
        drop = 0;
        if (pop) void'(q_m.pop_front());
        if (push) begin
            if (!full || pop) q_m.push_back(c);
            else drop = 1;
        end
        if (drop) ovf_m = 1;
        else if (clr) ovf_m = 0;
    endfunction

    task automatic step(input bit r, input bit n, input int c, input bit rdy, input bit clr);
        rst       = r;
        none_in   = n;
        code_in   = 3'(c);
        out_ready = rdy;
        ovf_clr   = clr;
        @(posedge clk);
        model_update(r, n, c, rdy, clr);
        #1;
        chk("out_valid", int'(out_valid), (q_m.size() > 0) ? 1 : 0);
        chk("out_code", int'(out_code), (q_m.size() > 0) ? q_m[0] : 0);
        chk("level", int'(level), q_m.size());
        chk("overflow", int'(overflow), int'(ovf_m));
    endtask

    task automatic press(input int c, input int n_act, input int n_none, input bit rdy);
        for (int i = 0; i < n_act; i++) step(0, 0, c, rdy, 0);
        for (int i = 0; i < n_none; i++) step(0, 1, 0, rdy, 0);
    endtask

    task automatic do_reset();
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; none_in = 1'b1; code_in = '0; out_ready = 1'b0; ovf_clr = 1'b0;
        q_m.delete(); ovf_m = 0; held_m = 0; held_code_m = 0;
        last_valid_m = 0; last_key_m = 0; run_len_m = 0;

        // Reset state
        do_reset();
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_code", int'(out_code), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_ovf", int'(overflow), 0);

        // 1: single press of 5, consumer ready
        for (int i = 0; i < 3; i++) step(0, 0, 5, 1, 0);
        chk("t1_not_yet", int'(out_valid), 0);
        step(0, 0, 5, 1, 0);
        chk("t1_valid", int'(out_valid), 1);
        chk("t1_code", int'(out_code), 5);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 1, 0);
        chk("t1_level", int'(level), 0);

        // 2: unstable press never qualifies
        do_reset();
        press(3, 3, 1, 0);
        press(3, 3, 1, 0);
        chk("t2_level", int'(level), 0);

        // 3: roll-over from 6 to 2
        do_reset();
        press(6, 4, 0, 0);
        press(2, 4, 4, 0);
        chk("t3_level", int'(level), 2);
        chk("t3_head", int'(out_code), 6);
        step(0, 1, 0, 1, 0);
        chk("t3_second", int'(out_code), 2);

        // 4: overflow with consumer stalled, then clear and drain
        do_reset();
        for (int k = 0; k < 9; k++) press(k % 8, 4, 4, 0);
        chk("t4_level", int'(level), 8);
        chk("t4_ovf", int'(overflow), 1);
        step(0, 1, 0, 0, 1);
        chk("t4_ovf_clr", int'(overflow), 0);
        for (int k = 0; k < 8; k++) begin
            chk("t4_order", int'(out_code), k);
            step(0, 1, 0, 1, 0);
        end
        chk("t4_empty", int'(out_valid), 0);

        // 5: push and pop on the same edge while full
        do_reset();
        for (int k = 0; k < 8; k++) press(k, 4, 4, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 3, 0, 0);
        step(0, 0, 3, 1, 0);
        chk("t5_level", int'(level), 8);
        chk("t5_ovf", int'(overflow), 0);
        for (int k = 1; k < 8; k++) begin
            chk("t5_order", int'(out_code), k);
            step(0, 1, 0, 1, 0);
        end
        chk("t5_tail", int'(out_code), 3);

        // 6: reset with data stored and a press in qualification
        do_reset();
        press(1, 4, 4, 0);
        press(2, 4, 4, 0);
        press(4, 4, 4, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 6, 0, 0);
        step(1, 0, 6, 0, 0);
        chk("t6_level", int'(level), 0);
        chk("t6_valid", int'(out_valid), 0);
        chk("t6_code", int'(out_code), 0);
        for (int i = 0; i < 3; i++) step(0, 0, 6, 0, 0);
        chk("t6_fresh3", int'(level), 0);
        step(0, 0, 6, 0, 0);
        chk("t6_fresh4", int'(level), 1);
        chk("t6_fresh_code", int'(out_code), 6);

        // Random traffic: segments of repeated samples with random consumer behaviour
        do_reset();
        for (int seg = 0; seg < 900; seg++) begin
            bit n;
            int c, len;
            n   = ($urandom_range(0, 9) < 3);
            c   = $urandom_range(0, 7);
            len = $urandom_range(1, 7);
            for (int i = 0; i < len; i++) begin
                step(($urandom_range(0, 499) == 0), n, c,
                     ($urandom_range(0, 9) < 4), ($urandom_range(0, 19) == 0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
